// File: rtl/inst_queue_pkg.sv
// Shared defines for the instruction fetch queue: depth default, common constants
// and the queued entry payload.
package inst_queue_pkg;

    localparam int unsigned IFQ_DEPTH = 4;

    localparam logic        Valid     = 1'b1;
    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] Zero      = 32'h0000_0000;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_mem.sv
// Entry storage for inst_queue: DEPTH x 64 register array, synchronous write,
// asynchronous read. Contents are never cleared; validity lives in the pointers.
module ifq_mem
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  ifq_entry_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output ifq_entry_t        rdata
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction fetch queue between fetch and decode: strict FIFO with flush.
// Optional stall counter enabled by defining IFQ_STALL_CNT_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
`ifdef IFQ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             push, pop;
    ifq_entry_t       wr_entry, rd_entry;

    // Handshake flags derive only from the registered count.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != CNT_W'(Zero));

    assign push = (in_valid == Valid) && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (push) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Reset outranks flush; both drop every queued entry.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rd_ptr <= PTR_W'(Zero);
            wr_ptr <= PTR_W'(Zero);
            count  <= CNT_W'(Zero);
        end else if (flush) begin
            rd_ptr <= PTR_W'(Zero);
            wr_ptr <= PTR_W'(Zero);
            count  <= CNT_W'(Zero);
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
        end
    end

    assign wr_entry.pc   = in_pc;
    assign wr_entry.inst = in_inst;

    ifq_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && (rst != RstEnable)),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign out_pc   = rd_entry.pc;
    assign out_inst = rd_entry.inst;

`ifdef IFQ_STALL_CNT_EN
    // Cycles fetch offered but was blocked by a full queue; saturating, flush-immune.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cnt <= Zero;
        end else if ((in_valid == Valid) && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH = 4).
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [2:0]  count;
`ifdef IFQ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    inst_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
`ifdef IFQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst_of(pc);
    endtask

    initial begin
        logic [31:0] exp_pc [4];

        rst = 1'b1; flush = 1'b1; out_ready = 1'b0;
        offer(1'b1, 32'h0000_0000);
        step();
        rst = 1'b0; flush = 1'b0;
        offer(1'b0, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Three pushes with decode stalled
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'(i * 4));
            step();
        end
        offer(1'b0, 32'h0);
        check("push3_count", 32'(count), 32'd3);
        check("push3_out_pc", out_pc, 32'h0000_0000);
        check("push3_out_inst", out_inst, inst_of(32'h0000_0000));
        check("push3_in_ready", 32'(in_ready), 32'd1);
        check("push3_out_valid", 32'(out_valid), 32'd1);

        // Fill, then hold an offer against a full queue
        offer(1'b1, 32'h0000_000C);
        step();
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        offer(1'b1, 32'h0000_0100);
        for (int i = 0; i < 3; i++) step();
        check("hold_count", 32'(count), 32'd4);
        check("hold_out_pc", out_pc, 32'h0000_0000);
`ifdef IFQ_STALL_CNT_EN
        check("hold_stall_cnt", stall_cnt, 32'd3);
`endif

        // Push and pop together while full: only the pop happens
        out_ready = 1'b1;
        step();
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_in_ready", 32'(in_ready), 32'd1);
        check("fullpop_out_pc", out_pc, 32'h0000_0004);
        out_ready = 1'b0;
        offer(1'b1, 32'h0000_0010);
        step();
        offer(1'b0, 32'h0);
        check("refill_count", 32'(count), 32'd4);
        check("refill_in_ready", 32'(in_ready), 32'd0);
`ifdef IFQ_STALL_CNT_EN
        check("refill_stall_cnt", stall_cnt, 32'd4);
`endif

        // Drain and confirm order and absence of the blocked 0x100 offer
        exp_pc[0] = 32'h04; exp_pc[1] = 32'h08; exp_pc[2] = 32'h0C; exp_pc[3] = 32'h10;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_pc%0d", i), out_pc, exp_pc[i]);
            check($sformatf("drain_inst%0d", i), out_inst, inst_of(exp_pc[i]));
            step();
        end
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);
        step();
        check("empty_pop_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Flush with a concurrent offer
        offer(1'b1, 32'h0000_0010); step();
        offer(1'b1, 32'h0000_0014); step();
        check("preflush_count", 32'(count), 32'd2);
        check("preflush_out_pc", out_pc, 32'h0000_0010);
        flush = 1'b1;
        offer(1'b1, 32'h0000_0018);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        check("flush_no_0x18", 32'(count), 32'd0);
`ifdef IFQ_STALL_CNT_EN
        check("flush_stall_cnt", stall_cnt, 32'd4);
`endif

        // Continuous push+pop stream of 10 instructions
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, 32'(i * 4));
            step();
            check($sformatf("stream_pc%0d", i), out_pc, 32'(i * 4));
            check($sformatf("stream_cnt%0d", i), 32'(count), 32'd1);
        end
        offer(1'b0, 32'h0);
        step();
        check("stream_end_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Reset mid-operation with flush asserted
        offer(1'b1, 32'h0000_0040); step();
        offer(1'b1, 32'h0000_0044); step();
        check("prerst_count", 32'(count), 32'd2);
        rst = 1'b1; flush = 1'b1;
        offer(1'b1, 32'h0000_0048);
        step();
        rst = 1'b0; flush = 1'b0;
        offer(1'b0, 32'h0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
`ifdef IFQ_STALL_CNT_EN
        check("midrst_stall_cnt", stall_cnt, 32'd0);
`endif

        // Pointers restart at zero after reset
        offer(1'b1, 32'h0000_0050); step();
        offer(1'b0, 32'h0);
        check("postrst_count", 32'(count), 32'd1);
        check("postrst_out_pc", out_pc, 32'h0000_0050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
